// File: rtl/prog_mealy_fsm_pkg.sv
// Shared types and helpers for the table-driven Mealy FSM: entry layout,
// power-on table contents and state legality.
package prog_mealy_fsm_pkg;

  localparam int MAX_W = 8;

  typedef struct packed {
    logic [MAX_W-1:0] next_state;
    logic [MAX_W-1:0] out;
  } entry_t;

  // Legacy 4-state machine, indexed {state, symbol}
  localparam int LEGACY_NEXT [16] = '{0, 3, 1, 2,  1, 1, 2, 0,  3, 2, 3, 1,  0, 3, 2, 1};
  localparam int LEGACY_OUT  [16] = '{0, 1, 0, 0,  1, 0, 1, 1,  0, 1, 0, 1,  1, 1, 1, 1};

  function automatic entry_t default_entry(input int state_w, input int in_w,
                                           input int out_w, input int n_states,
                                           input int idx);
    entry_t e;
    int     st;
    e  = '0;
    st = idx >> in_w;
    if (state_w == 2 && in_w == 2 && out_w == 1 && n_states == 4) begin
      e.next_state = MAX_W'(LEGACY_NEXT[idx[3:0]]);
      e.out        = MAX_W'(LEGACY_OUT[idx[3:0]]);
    end else begin
      e.next_state = (st < n_states) ? MAX_W'(st) : '0;
    end
    return e;
  endfunction

  function automatic logic is_legal(input int n_states, input int value);
    return value < n_states;
  endfunction

endpackage

// File: rtl/prog_mealy_fsm_if.sv
// Step, status and table-programming signals of prog_mealy_fsm.
// PROG_MEALY_FSM_READBACK_EN adds the registered cfg_rdata return path.
interface prog_mealy_fsm_if #(
  parameter int STATE_W = 2,
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1
);
  logic                     in_valid;
  logic [IN_W-1:0]          in_data;
  logic                     out_valid;
  logic [OUT_W-1:0]         out_data;
  logic [STATE_W-1:0]       state;
  logic                     cfg_we;
  logic [STATE_W+IN_W-1:0]  cfg_addr;
  logic [STATE_W+OUT_W-1:0] cfg_wdata;
  logic                     err;
`ifdef PROG_MEALY_FSM_READBACK_EN
  logic [STATE_W+OUT_W-1:0] cfg_rdata;
`endif

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_wdata,
    input  out_valid, out_data, state, err
`ifdef PROG_MEALY_FSM_READBACK_EN
    , input cfg_rdata
`endif
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_wdata,
    output out_valid, out_data, state, err
`ifdef PROG_MEALY_FSM_READBACK_EN
    , output cfg_rdata
`endif
  );
endinterface

// File: rtl/prog_mealy_fsm_fsm_table.sv
// Transition table register file: resettable defaults, one write port,
// combinational step read; PROG_MEALY_FSM_READBACK_EN adds registered readback.
module fsm_table
  import prog_mealy_fsm_pkg::*;
#(
  parameter int STATE_W  = 2,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 1,
  parameter int N_STATES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [STATE_W+IN_W-1:0]  addr,
  input  logic [STATE_W+OUT_W-1:0] wdata,
  input  logic [STATE_W+IN_W-1:0]  raddr,
  output logic [STATE_W+OUT_W-1:0] rdata
`ifdef PROG_MEALY_FSM_READBACK_EN
  , output logic [STATE_W+OUT_W-1:0] cfg_rdata
`endif
);
  localparam int ENT_W = STATE_W + OUT_W;
  localparam int DEPTH = 1 << (STATE_W + IN_W);

  logic [ENT_W-1:0] mem [DEPTH];

  function automatic logic [ENT_W-1:0] reset_word(input int idx);
    entry_t e;
    e = default_entry(STATE_W, IN_W, OUT_W, N_STATES, idx);
    return {e.next_state[STATE_W-1:0], e.out[OUT_W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= reset_word(i);
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Old contents on a same-cycle write to the stepped entry
  assign rdata = mem[raddr];

`ifdef PROG_MEALY_FSM_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset)   cfg_rdata <= '0;
    else if (we) cfg_rdata <= wdata;
    else         cfg_rdata <= mem[addr];
  end
`endif

endmodule

// File: rtl/prog_mealy_fsm.sv
// Table-driven Mealy FSM: state/output/err registers and write legality.
// Optional PROG_MEALY_FSM_READBACK_EN exposes cfg_rdata through the table.
//   state         | meaning
//   0             | reset / entry state
//   1..N_STATES-1 | behaviour defined by the transition table
module prog_mealy_fsm
  import prog_mealy_fsm_pkg::*;
#(
  parameter int STATE_W  = 2,
  parameter int N_STATES = 4,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 1
) (
  input logic             clk,
  input logic             reset,
  prog_mealy_fsm_if.slave bus
);
  localparam int ADDR_W = STATE_W + IN_W;
  localparam int ENT_W  = STATE_W + OUT_W;

  logic [STATE_W-1:0] cur_state;
  logic [OUT_W-1:0]   out_reg;
  logic               out_valid_reg;
  logic               err_reg;
  logic [ENT_W-1:0]   step_entry;
  logic               wr_legal;
  logic               wr_en;

  assign wr_legal = is_legal(N_STATES, int'(bus.cfg_addr[ADDR_W-1 -: STATE_W])) &&
                    is_legal(N_STATES, int'(bus.cfg_wdata[ENT_W-1 -: STATE_W]));
  assign wr_en    = bus.cfg_we && wr_legal;

  fsm_table #(
    .STATE_W (STATE_W),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .N_STATES(N_STATES)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (wr_en),
    .addr     (bus.cfg_addr),
    .wdata    (bus.cfg_wdata),
    .raddr    ({cur_state, bus.in_data}),
    .rdata    (step_entry)
`ifdef PROG_MEALY_FSM_READBACK_EN
    , .cfg_rdata(bus.cfg_rdata)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state     <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        cur_state <= step_entry[ENT_W-1 -: STATE_W];
        out_reg   <= step_entry[OUT_W-1:0];
      end
      if (bus.cfg_we && !wr_legal) err_reg <= 1'b1;
    end
  end

  assign bus.state     = cur_state;
  assign bus.out_data  = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Scoreboard bench for prog_mealy_fsm: random and directed steps/writes on a
// 4-state instance against a table model, plus a 3-state instance for err.
module tb_prog_mealy_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset3 = 1'b1;
  always #5 clk = ~clk;

  prog_mealy_fsm_if #(.STATE_W(2), .IN_W(2), .OUT_W(1)) bus ();
  prog_mealy_fsm_if #(.STATE_W(2), .IN_W(2), .OUT_W(1)) bus3 ();

  prog_mealy_fsm #(.STATE_W(2), .N_STATES(4), .IN_W(2), .OUT_W(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  prog_mealy_fsm #(.STATE_W(2), .N_STATES(3), .IN_W(2), .OUT_W(1)) dut3 (
    .clk(clk), .reset(reset3), .bus(bus3));

  typedef struct {int st; int od;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference: legacy machine written as "state: symbol -> next/out"
  int def_next [16] = '{0, 3, 1, 2,  1, 1, 2, 0,  3, 2, 3, 1,  0, 3, 2, 1};
  int def_out  [16] = '{0, 1, 0, 0,  1, 0, 1, 1,  0, 1, 0, 1,  1, 1, 1, 1};
  int m_next [16];
  int m_out  [16];
  int m_state, m_od, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_next[i] = def_next[i];
      m_out[i]  = def_out[i];
    end
    m_state = 0;
    m_od    = 0;
    m_err   = 0;
  endtask

  task automatic step(input bit iv, input int data, input bit we, input int addr, input int wd);
    int idx;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = data[1:0];
    bus.cfg_we    = we;
    bus.cfg_addr  = addr[3:0];
    bus.cfg_wdata = wd[2:0];
    if (iv) begin
      idx = m_state * 4 + data;
      exp_q.push_back('{m_next[idx], m_out[idx]});
      m_state = m_next[idx];
      m_od    = m_out[idx];
    end
    if (we) begin
      if ((addr / 4) < 4 && (wd / 2) < 4) begin
        m_next[addr] = wd / 2;
        m_out[addr]  = wd % 2;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic idle_check(input int n, input int data);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = data[1:0];
      bus.cfg_we   = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_state", int'(bus.state), m_state);
      chk("hold_out_valid", int'(bus.out_valid), 0);
      chk("hold_out_data", int'(bus.out_data), m_od);
      chk("hold_err", int'(bus.err), m_err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 2'b01;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'b0000;
    bus.cfg_wdata = 3'b101;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_err", int'(bus.err), 0);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic legacy_seq();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("legacy_seq_end_state", int'(bus.state), 0);
    chk("legacy_seq_end_out", int'(bus.out_data), 1);
  endtask

  // Monitor: every out_valid pulse must match the oldest pending step
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: out_valid with no pending step at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_state", int'(bus.state), e.st);
        chk("sb_out_data", int'(bus.out_data), e.od);
      end
    end
  end

  task automatic step3(input bit iv, input int data, input bit we, input int addr, input int wd);
    @(negedge clk);
    bus3.in_valid  = iv;
    bus3.in_data   = data[1:0];
    bus3.cfg_we    = we;
    bus3.cfg_addr  = addr[3:0];
    bus3.cfg_wdata = wd[2:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.cfg_we    = 1'b0;
    bus3.cfg_addr  = '0;
    bus3.cfg_wdata = '0;
    model_reset();

    do_reset();
    legacy_seq();

    // reach state 2 and hold with in_valid low
    step(1, 3, 0, 0, 0);
    idle_check(3, 0);

    // write {0,00} <= {2,1}, then step 00 from state 0
    step(1, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 4'b0000, 3'b101);
    step(1, 0, 0, 0, 0);
    idle_check(1, 0);

    // same-cycle write {0,01} <= {1,0} and step 01 from state 0
    step(1, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(1, 1, 1, 4'b0001, 3'b010);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    idle_check(1, 0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 7));
    end
    idle_check(2, 0);

    // program 4 entries, step a little, then reset mid-stream
    for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom_range(0, 15), $urandom_range(0, 7));
    for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 3), 0, 0, 0);
    do_reset();
    legacy_seq();
    idle_check(1, 0);

`ifdef PROG_MEALY_FSM_READBACK_EN
    @(negedge clk);
    bus.cfg_addr = 4'b0110;
    @(posedge clk);
    #1;
    chk("readback_1_10", int'(bus.cfg_rdata), 5);
`endif

    // 3-state instance: illegal writes set sticky err, table untouched
    @(negedge clk);
    reset3 = 1'b1;
    @(posedge clk);
    #1;
    chk("n3_rst_err", int'(bus3.err), 0);
    @(negedge clk);
    reset3 = 1'b0;
    step3(0, 0, 1, 4'b0000, 3'b111);
    chk("n3_err_next_state", int'(bus3.err), 1);
    step3(1, 0, 0, 0, 0);
    chk("n3_unchanged_state", int'(bus3.state), 0);
    chk("n3_unchanged_out", int'(bus3.out_data), 0);
    chk("n3_unchanged_valid", int'(bus3.out_valid), 1);
    step3(0, 0, 1, 4'b1101, 3'b010);
    step3(0, 0, 1, 4'b0001, 3'b101);
    chk("n3_err_sticky", int'(bus3.err), 1);
    step3(1, 1, 0, 0, 0);
    chk("n3_legal_state", int'(bus3.state), 2);
    chk("n3_legal_out", int'(bus3.out_data), 1);
    step3(0, 0, 0, 0, 0);
    step3(0, 0, 0, 0, 0);
    chk("n3_err_held", int'(bus3.err), 1);
    @(negedge clk);
    reset3 = 1'b1;
    @(posedge clk);
    #1;
    chk("n3_err_cleared", int'(bus3.err), 0);
    @(negedge clk);
    reset3 = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
